load_store_unit: RTL and testbench

Sequential memory-access stage between the core's execute stage and `data_memory`. Accepts one byte, halfword or word load/store request per handshake and converts the byte address to `data_memory`'s word index. Performs sub-word stores as read-modify-write sequences. Returns loads zero- or sign-extended. All memory-side outputs are registered, so `data_memory`'s level-sensitive write sees one clean `MemWrite` pulse per store.

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores to data_memory, sub-word stores as read-modify-write.
// Latency: load 2 cycles, word store 2, sub-word store 3, error 1 (LSU_MISALIGN_TRAP_EN traps misaligned/illegal requests).
// Backpressure: req_ready only in IDLE; a requester holds its fields until accepted.
module load_store_unit #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data
);

    typedef enum logic [1:0] {IDLE, RD, RMW, WR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  size_q, lane_q;
    logic        signed_q;
    logic [31:0] wdata_q;

    logic [1:0]  eff_size, eff_lane;
    logic        req_err;
    logic [31:0] idx;
    logic [4:0]  lane_shift;
    logic [31:0] rd_shifted, load_val, merge_mask, merged;

    logic        capture;
    logic        mem_rd_nxt, mem_wr_nxt, resp_valid_nxt, resp_err_nxt;
    logic [31:0] addr_nxt, wdata_nxt, rdata_nxt;

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign idx       = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
    assign req_ready = (state == IDLE);

    // Alignment policy: trap, or silently clear the offending low address bits.
    always_comb begin
        eff_size = req_size;
        eff_lane = req_addr[1:0];
        req_err  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
        case (req_size)
            2'b01:        eff_lane = {req_addr[1], 1'b0};
            2'b10, 2'b11: begin
                eff_size = 2'b10;
                eff_lane = 2'b00;
            end
            default: ;
        endcase
`endif
    end

    assign lane_shift = {lane_q, 3'b000};
    assign rd_shifted = Read_data >> lane_shift;
    assign merge_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
    assign merged     = (Read_data & ~merge_mask) | ((wdata_q << lane_shift) & merge_mask);

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_val = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_val = Read_data;
        endcase
    end

    // Next-state and next values of every registered output.
    always_comb begin
        state_nxt      = state;
        capture        = 1'b0;
        mem_rd_nxt     = 1'b0;
        mem_wr_nxt     = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        rdata_nxt      = 32'h0;
        addr_nxt       = Address;
        wdata_nxt      = Write_data;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else begin
                        capture  = 1'b1;
                        addr_nxt = idx;
                        if (!req_write) begin
                            state_nxt  = RD;
                            mem_rd_nxt = 1'b1;
                        end else if (eff_size == 2'b10) begin
                            state_nxt  = WR;
                            mem_wr_nxt = 1'b1;
                            wdata_nxt  = req_wdata;
                        end else begin
                            state_nxt  = RMW;
                            mem_rd_nxt = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                rdata_nxt      = load_val;
                resp_valid_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            RMW: begin
                wdata_nxt  = merged;
                mem_wr_nxt = 1'b1;
                state_nxt  = WR;
            end
            WR: begin
                resp_valid_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Address    <= 32'h0;
            Write_data <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            signed_q   <= 1'b0;
            wdata_q    <= 32'h0;
        end else begin
            state      <= state_nxt;
            MemRead    <= mem_rd_nxt;
            MemWrite   <= mem_wr_nxt;
            Address    <= addr_nxt;
            Write_data <= wdata_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= rdata_nxt;
            if (capture) begin
                size_q   <= eff_size;
                lane_q   <= eff_lane;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of requests against a word-array memory model, plus busy-hold and reset-abort sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] Address, Write_data, Read_data;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_idx;
        logic [31:0] exp_wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[16];

    load_store_unit #(.IDX_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data)
    );

    always #5 clk = ~clk;

    assign Read_data = mem[Address[5:0]];
    always @(posedge clk) if (MemWrite) mem[Address[5:0]] <= Write_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name);
        exp_t e;
        check({name, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, " strobes idle"}, {30'b0, MemRead, MemWrite}, 32'd0);
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " rdata"}, resp_rdata, e.rdata);
            check({name, " err"}, {31'b0, resp_err}, {31'b0, e.err});
        end
    endtask

    // Entered and left on a falling edge.
    task automatic run_req(input vec_t v, input string name);
        int n;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check({name, " ready timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (v.exp_rd) begin
            check({name, " rd strobe"}, {30'b0, MemRead, MemWrite}, 32'd2);
            check({name, " rd Address"}, Address, v.exp_idx);
            @(negedge clk);
        end
        if (v.exp_wr) begin
            check({name, " wr strobe"}, {30'b0, MemRead, MemWrite}, 32'd1);
            check({name, " wr Address"}, Address, v.exp_idx);
            check({name, " Write_data"}, Write_data, v.exp_wd);
            @(negedge clk);
        end
        check_resp(name);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[3] = 32'h8899_AABB;

        vecs[0]  = '{0, 2'd2, 0, 32'h0C,  32'h0,         1, 0, 32'd3, 32'h0,         32'h8899_AABB, 0};
        vecs[1]  = '{0, 2'd0, 1, 32'h0D,  32'h0,         1, 0, 32'd3, 32'h0,         32'hFFFF_FFAA, 0};
        vecs[2]  = '{0, 2'd0, 0, 32'h0D,  32'h0,         1, 0, 32'd3, 32'h0,         32'h0000_00AA, 0};
        vecs[3]  = '{0, 2'd1, 1, 32'h0E,  32'h0,         1, 0, 32'd3, 32'h0,         32'hFFFF_8899, 0};
        vecs[4]  = '{0, 2'd1, 0, 32'h0E,  32'h0,         1, 0, 32'd3, 32'h0,         32'h0000_8899, 0};
        vecs[5]  = '{0, 2'd0, 1, 32'h0C,  32'h0,         1, 0, 32'd3, 32'h0,         32'hFFFF_FFBB, 0};
        vecs[6]  = '{0, 2'd0, 0, 32'h0F,  32'h0,         1, 0, 32'd3, 32'h0,         32'h0000_0088, 0};
        vecs[7]  = '{1, 2'd0, 0, 32'h0E,  32'hFFFF_FF55, 1, 1, 32'd3, 32'h8855_AABB, 32'h0,         0};
        vecs[8]  = '{0, 2'd2, 0, 32'h0C,  32'h0,         1, 0, 32'd3, 32'h0,         32'h8855_AABB, 0};
        vecs[9]  = '{1, 2'd2, 0, 32'h110, 32'h1234_5678, 0, 1, 32'd4, 32'h1234_5678, 32'h0,         0};
        vecs[10] = '{0, 2'd2, 0, 32'h10,  32'h0,         1, 0, 32'd4, 32'h0,         32'h1234_5678, 0};
        vecs[11] = '{1, 2'd1, 0, 32'h12,  32'hFFFF_BEEF, 1, 1, 32'd4, 32'hBEEF_5678, 32'h0,         0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = '{0, 2'd1, 1, 32'h0D,  32'h0,         0, 0, 32'd0, 32'h0,         32'h0,         1};
        vecs[13] = '{0, 2'd3, 0, 32'h13,  32'h0,         0, 0, 32'd0, 32'h0,         32'h0,         1};
        vecs[14] = '{0, 2'd2, 0, 32'h12,  32'h0,         0, 0, 32'd0, 32'h0,         32'h0,         1};
`else
        vecs[12] = '{0, 2'd1, 1, 32'h0D,  32'h0,         1, 0, 32'd3, 32'h0,         32'hFFFF_AABB, 0};
        vecs[13] = '{0, 2'd3, 0, 32'h13,  32'h0,         1, 0, 32'd4, 32'h0,         32'hBEEF_5678, 0};
        vecs[14] = '{0, 2'd2, 0, 32'h12,  32'h0,         1, 0, 32'd4, 32'h0,         32'hBEEF_5678, 0};
`endif
        vecs[15] = '{0, 2'd0, 1, 32'h13,  32'h0,         1, 0, 32'd4, 32'h0,         32'hFFFF_FFBE, 0};

        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset strobes/resp", {28'b0, MemRead, MemWrite, resp_valid, resp_err}, 32'd0);
        check("reset Address", Address, 32'h0);
        check("reset Write_data", Write_data, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // Store with req_valid held: the follow-on load waits for req_ready.
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h14; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_write = 1'b0;
        @(negedge clk);
        check("busy ready low", {31'b0, req_ready}, 32'd0);
        check("busy wr strobe", {30'b0, MemRead, MemWrite}, 32'd1);
        check("busy wr Address", Address, 32'd5);
        @(negedge clk);
        check_resp("busy store");
        check("busy ready back", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("busy load rd strobe", {30'b0, MemRead, MemWrite}, 32'd2);
        check("busy load Address", Address, 32'd5);
        @(negedge clk);
        check_resp("busy load");

        // Reset while a load sits in RD.
        req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0C; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort rd strobe", {31'b0, MemRead}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort MemRead async", {31'b0, MemRead}, 32'd0);
        check("abort req_ready", {31'b0, req_ready}, 32'd1);
        check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort no resp %0d", i), {31'b0, resp_valid}, 32'd0);
        end
        v = vecs[8];
        run_req(v, "after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
